// File: rtl/md5_block_builder.sv
`default_nettype none
`timescale 1ns/1ps
// +---------------------------------------------------------------------------+
// | md5_block_builder : byte stream -> single padded MD5 block, ping-pong     |
// |                     buffered for the round engine (word-addressed read)   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module md5_block_builder #(
  parameter int MAXLEN = 55
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  input  logic [3:0]  gaddr_i,
  output logic [31:0] mdata_o,
  output logic        blk_valid_o,
  output logic [5:0]  blk_len_o,
  input  logic        blk_release_i,
  output logic        err_trunc_o
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_PUB  = 2'd2
  } state_t;

  localparam logic [5:0] c_last_idx = 6'(MAXLEN - 1);

  state_t      state_q;
  logic [5:0]  count_q;
  logic [5:0]  n_q;
  logic [3:0]  w_q;
  logic        drain_q;
  logic        wb_q;
  logic        rb_q;
  logic [1:0]  full_q;
  logic [1:0]  full_d;
  logic [5:0]  len_q  [0:1];
  logic [31:0] bank_q [0:1][0:15];

  logic        w_accept;
  logic        w_fill_acc;
  logic        w_hit_max;
  logic        w_fill_end;
  logic        w_drain_done;
  logic        w_publish;
  logic        w_release;
  logic [5:0]  w_cnt_inc;
  logic [31:0] w_keep_mask;
  logic [31:0] w_marker;
  logic [31:0] w_pad_word;

  // Drain keeps accepting bytes even while padding words are being written.
  assign in_ready_o   = (state_q == S_FILL) ? !full_q[wb_q] : drain_q;
  assign w_accept     = in_valid_i & in_ready_o;
  assign w_fill_acc   = w_accept & (state_q == S_FILL);
  assign w_hit_max    = (count_q == c_last_idx);
  assign w_fill_end   = w_fill_acc & (in_last_i | w_hit_max);
  assign w_cnt_inc    = count_q + 6'd1;
  assign err_trunc_o  = w_fill_acc & w_hit_max & !in_last_i;
  assign w_drain_done = drain_q & w_accept & in_last_i & (state_q != S_FILL);
  assign w_publish    = (state_q == S_PUB) & !drain_q;
  assign w_release    = blk_release_i & full_q[rb_q];

  assign blk_valid_o  = full_q[rb_q];
  assign blk_len_o    = len_q[rb_q];
  assign mdata_o      = bank_q[rb_q][gaddr_i];

  always_comb begin
    w_keep_mask = 32'h0000_0000;
    w_marker    = 32'h0000_0080;
    case (n_q[1:0])
      2'd1: begin w_keep_mask = 32'h0000_00FF; w_marker = 32'h0000_8000; end
      2'd2: begin w_keep_mask = 32'h0000_FFFF; w_marker = 32'h0080_0000; end
      2'd3: begin w_keep_mask = 32'h00FF_FFFF; w_marker = 32'h8000_0000; end
      default: ;
    endcase
  end

  always_comb begin
    w_pad_word = 32'h0000_0000;
    if (w_q == n_q[5:2]) begin
      w_pad_word = (bank_q[wb_q][w_q] & w_keep_mask) | w_marker;
    end
    if (w_q == 4'd14) begin
      w_pad_word = w_pad_word | {23'd0, n_q, 3'b000};
    end
  end

  always_comb begin
    full_d = full_q;
    if (w_publish) full_d[wb_q] = 1'b1;
    if (w_release) full_d[rb_q] = 1'b0;
  end

  // Buffer storage carries no reset; a bank is only read once published.
  always_ff @(posedge clk_i) begin
    if (w_fill_acc) begin
      bank_q[wb_q][count_q[5:2]][{count_q[1:0], 3'b000} +: 8] <= in_data_i;
    end else if (state_q == S_PAD) begin
      bank_q[wb_q][w_q] <= w_pad_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_FILL;
      count_q  <= 6'd0;
      n_q      <= 6'd0;
      w_q      <= 4'd0;
      drain_q  <= 1'b0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      full_q   <= 2'b00;
      len_q[0] <= 6'd0;
      len_q[1] <= 6'd0;
    end else begin
      full_q <= full_d;
      if (w_release) rb_q <= ~rb_q;
      if (w_drain_done) drain_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (w_fill_acc) begin
            count_q <= w_cnt_inc;
            if (w_fill_end) begin
              n_q     <= w_cnt_inc;
              w_q     <= w_cnt_inc[5:2];
              drain_q <= !in_last_i;
              state_q <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (w_q == 4'd15) state_q <= S_PUB;
          else              w_q     <= w_q + 4'd1;
        end
        S_PUB: begin
          if (!drain_q) begin
            len_q[wb_q] <= n_q;
            wb_q        <= ~wb_q;
            count_q     <= 6'd0;
            state_q     <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/md5_block_builder.md
Name: md5_block_builder

Overview:
- Upstream feeder for the MD5 round engine (chunk cruncher).
- Takes one candidate password as a byte stream and builds the single padded 512-bit MD5 block in an internal two-bank (ping-pong) word buffer.
- Serves the published bank to the round engine, which reads it by word address (gaddr -> mdata).
- Ping-pong lets the next candidate fill while the current block is being crunched.

Parameters:
MAXLEN, 55, maximum candidate length in bytes (a single-block MD5 limit; must be <= 55)

Ports:
clk        input   1   clock
reset      input   1   synchronous, active-high reset
in_data    input   8   candidate byte
in_valid   input   1   in_data valid
in_last    input   1   current byte is the final byte of the candidate
in_ready   output  1   byte accepted when in_valid && in_ready
gaddr      input   4   word index requested by the round engine
mdata      output  32  word gaddr of the published bank (combinational read)
blk_valid  output  1   published bank holds a complete padded block
blk_len    output  6   byte length of the candidate in the published bank
blk_release input  1   one-cycle pulse: engine is finished with the published bank
err_trunc  output  1   one-cycle pulse: candidate exceeded MAXLEN and was truncated

Behaviour:
- Reset values:
  - state = FILL; count = 0; wb (write bank) = 0; rb (read bank) = 0; full[1:0] = 0.
  - blk_valid = 0, blk_len = 0, err_trunc = 0, in_ready = 1.
  - Bank RAM contents are not reset.
- Byte placement: byte k goes to word k>>2, bits 8*k[1:0]+7 : 8*k[1:0] (little-endian, MD5 order).
- FILL state:
  - in_ready = !full[wb].
  - Each accepted byte is written and count increments by 1.
  - Accepted byte with in_last, or the byte that makes count == MAXLEN, ends the fill. n = final count; go to PAD with w = n>>2.
  - If the MAXLEN-th byte arrives without in_last: err_trunc pulses the same cycle and next state is DRAIN.
- DRAIN state:
  - in_ready = 1; bytes are discarded until one with in_last is accepted.
  - Then PAD with n = MAXLEN.
  - PAD writes proceed in parallel with DRAIN: DRAIN only gates the transition to publication.
- PAD state:
  - in_ready = 0; one word written per cycle, w = n>>2 .. 15.
  - Word n>>2: lanes below n[1:0] keep their data, lane n[1:0] = 8'h80, higher lanes = 0.
  - Words (n>>2)+1 .. 13 = 0.
  - Word 14 = {n, 3'b000} zero-extended (bit length). Word 15 = 0.
  - Word 14 or 15 also takes the 0x80 byte if n>>2 is 14 or 15, which cannot occur for MAXLEN <= 55.
  - Latency: 16-(n>>2) cycles after the last byte.
- Publish: cycle after the word-15 write (and DRAIN finished):
  - full[wb] <= 1; stored length[wb] <= n; wb toggles; count <= 0; state -> FILL.
  - If full[new wb] is set, in_ready stays 0 until it is released.
- Read side:
  - blk_valid = full[rb]; blk_len = length[rb]; mdata = bank[rb][gaddr], no latency.
  - blk_release with blk_valid: full[rb] <= 0 and rb toggles next cycle.
  - blk_release with !blk_valid is ignored.
- Simultaneous publish and release on different banks: both take effect in the same cycle.
- The round engine only sees a stable bank: the write bank never equals rb while full[rb] = 1.
- Reset mid-fill or mid-pad: the partial candidate is abandoned and all flags return to their reset values.

Test Plan:
1. Send "abc" (61 62 63, last on 63) -> after 16 pad cycles blk_valid = 1, blk_len = 3, word0 = 32'h80636261, words1-13 = 0, word14 = 32'h00000018, word15 = 0.
2. Send 4-byte "abcd" -> word0 = 32'h64636261, word1 = 32'h00000080, word14 = 32'h20.
3. Send 56 bytes of 0x41 with last on byte 56 -> err_trunc pulses on byte 55; blk_len = 55; word13 = 32'h80414141; word14 = 32'h1B8.
4. Publish two candidates without release -> both banks full and in_ready = 0 during the third candidate. Release once -> rb flips, blk_len shows the second length, and in_ready returns to 1 the next cycle.
5. Pulse blk_release with blk_valid = 0 -> no state change. Release in the same cycle as a publish -> blk_valid stays 1, showing the new bank.
6. Assert reset mid-PAD -> next cycle blk_valid = 0, in_ready = 1. A fresh "abc" then produces the same block as scenario 1.
